// File: rtl/i2c_reg_target.sv
// I2C target giving an external controller byte-wide access to the config/status register bank.
// Oversamples synchronized SCL/SDA on clk; SDA is open-drain (pull low via sda_oe only).
module i2c_reg_target #(
  parameter logic [6:0]  I2C_ADDR   = 7'h70,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned NUM_CFG    = 8,
  parameter int unsigned REG_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rstb,
  input  logic                  ena,
  input  logic                  scl,
  input  logic                  sda_i,
  output logic                  sda_o,
  output logic                  sda_oe,
  output logic [ADDR_WIDTH-1:0] reg_addr,
  output logic [REG_WIDTH-1:0]  reg_wdata,
  output logic                  reg_we,
  input  logic [REG_WIDTH-1:0]  reg_rdata,
  output logic                  busy
);

  localparam logic [3:0] StIdle     = 4'd0;
  localparam logic [3:0] StAddr     = 4'd1;
  localparam logic [3:0] StAddrAck  = 4'd2;
  localparam logic [3:0] StPtr      = 4'd3;
  localparam logic [3:0] StPtrAck   = 4'd4;
  localparam logic [3:0] StWdata    = 4'd5;
  localparam logic [3:0] StWrInc    = 4'd6;
  localparam logic [3:0] StWdataAck = 4'd7;
  localparam logic [3:0] StRdata    = 4'd8;
  localparam logic [3:0] StRack     = 4'd9;

  logic [3:0]            state_q, state_d;
  logic                  scl_q, sda_q;
  logic [7:0]            shift_q, shift_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  ack_q, ack_d;
  logic                  rw_q, rw_d;
  logic                  sda_oe_q, sda_oe_d;
  logic [ADDR_WIDTH-1:0] reg_addr_q, reg_addr_d;
  logic [REG_WIDTH-1:0]  reg_wdata_q, reg_wdata_d;
  logic                  reg_we_q, reg_we_d;
  logic                  busy_q;

  logic       scl_rise, scl_fall, start_det, stop_det;
  logic [7:0] byte_w;

  assign scl_rise  = scl & ~scl_q;
  assign scl_fall  = ~scl & scl_q;
  assign start_det = scl & scl_q & sda_q & ~sda_i;
  assign stop_det  = scl & scl_q & ~sda_q & sda_i;
  assign byte_w    = {shift_q[6:0], sda_i};

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    ack_d       = ack_q;
    rw_d        = rw_q;
    sda_oe_d    = sda_oe_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    reg_we_d    = 1'b0;

    if (start_det) begin
      state_d  = StAddr;
      cnt_d    = 4'd0;
      ack_d    = 1'b0;
      sda_oe_d = 1'b0;
    end else if (stop_det) begin
      state_d  = StIdle;
      cnt_d    = 4'd0;
      ack_d    = 1'b0;
      sda_oe_d = 1'b0;
    end else begin
      case (state_q)
        StIdle: ;
        StAddr, StPtr, StWdata: begin
          if (scl_rise) begin
            shift_d = byte_w;
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              cnt_d = 4'd0;
              if (state_q == StAddr) begin
                rw_d    = byte_w[0];
                state_d = (byte_w[7:1] == I2C_ADDR) ? StAddrAck : StIdle;
              end else if (state_q == StPtr) begin
                reg_addr_d = byte_w[ADDR_WIDTH-1:0];
                state_d    = StPtrAck;
              end else begin
                reg_wdata_d = byte_w;
                reg_we_d    = (32'(reg_addr_q) < NUM_CFG);
                state_d     = StWrInc;
              end
            end
          end
        end
        // Pointer advances one cycle after the strobe so address is stable while reg_we is high.
        StWrInc: begin
          reg_addr_d = reg_addr_q + ADDR_WIDTH'(1);
          state_d    = StWdataAck;
        end
        StAddrAck, StPtrAck, StWdataAck: begin
          if (scl_fall) begin
            if (!ack_q) begin
              sda_oe_d = 1'b1;
              ack_d    = 1'b1;
            end else begin
              ack_d    = 1'b0;
              sda_oe_d = 1'b0;
              cnt_d    = 4'd0;
              if (state_q != StAddrAck) begin
                state_d = StWdata;
              end else if (!rw_q) begin
                state_d = StPtr;
              end else begin
                // Read: first data bit must be on the bus in this same low phase.
                sda_oe_d   = ~reg_rdata[7];
                shift_d    = {reg_rdata[6:0], 1'b0};
                cnt_d      = 4'd1;
                reg_addr_d = reg_addr_q + ADDR_WIDTH'(1);
                state_d    = StRdata;
              end
            end
          end
        end
        StRdata: begin
          if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              sda_oe_d = 1'b0;
              cnt_d    = 4'd0;
              state_d  = StRack;
            end else begin
              sda_oe_d = ~shift_q[7];
              shift_d  = {shift_q[6:0], 1'b0};
              cnt_d    = cnt_q + 4'd1;
            end
          end
        end
        StRack: begin
          if (scl_rise) begin
            if (!sda_i) begin
              shift_d    = reg_rdata;
              cnt_d      = 4'd0;
              reg_addr_d = reg_addr_q + ADDR_WIDTH'(1);
              state_d    = StRdata;
            end else begin
              state_d = StIdle;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q     <= StIdle;
      scl_q       <= 1'b1;
      sda_q       <= 1'b1;
      shift_q     <= 8'd0;
      cnt_q       <= 4'd0;
      ack_q       <= 1'b0;
      rw_q        <= 1'b0;
      sda_oe_q    <= 1'b0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      reg_we_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else if (ena) begin
      state_q     <= state_d;
      scl_q       <= scl;
      sda_q       <= sda_i;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      ack_q       <= ack_d;
      rw_q        <= rw_d;
      sda_oe_q    <= sda_oe_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      reg_we_q    <= reg_we_d;
      busy_q      <= (state_d != StIdle);
    end
  end

  assign sda_o     = 1'b0;
  assign sda_oe    = sda_oe_q;
  assign reg_addr  = reg_addr_q;
  assign reg_wdata = reg_wdata_q;
  assign reg_we    = reg_we_q;
  assign busy      = busy_q;

endmodule
